// File: rtl/vga_axil_arbiter.sv
// Shares one AXI4-Lite slave (vga register file) between NUM_M masters, one
// transaction at a time, with round-robin or fixed-priority arbitration.
module vga_axil_arbiter #(
    parameter int NUM_M  = 2,
    parameter int RR_EN  = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int GW     = $clog2(NUM_M)
) (
    input  logic                     clk,
    input  logic                     arst,
    // upstream masters, fields packed master 0 in the low slice
    input  logic [NUM_M-1:0]         m_awvalid,
    output logic [NUM_M-1:0]         m_awready,
    input  logic [NUM_M*ADDR_W-1:0]  m_awaddr,
    input  logic [NUM_M-1:0]         m_wvalid,
    output logic [NUM_M-1:0]         m_wready,
    input  logic [NUM_M*DATA_W-1:0]  m_wdata,
    input  logic [NUM_M*STRB_W-1:0]  m_wstrb,
    output logic [NUM_M-1:0]         m_bvalid,
    input  logic [NUM_M-1:0]         m_bready,
    output logic [NUM_M*2-1:0]       m_bresp,
    input  logic [NUM_M-1:0]         m_arvalid,
    output logic [NUM_M-1:0]         m_arready,
    input  logic [NUM_M*ADDR_W-1:0]  m_araddr,
    output logic [NUM_M-1:0]         m_rvalid,
    input  logic [NUM_M-1:0]         m_rready,
    output logic [NUM_M*DATA_W-1:0]  m_rdata,
    output logic [NUM_M*2-1:0]       m_rresp,
    // shared slave
    output logic                     s_awvalid,
    input  logic                     s_awready,
    output logic [ADDR_W-1:0]        s_awaddr,
    output logic                     s_wvalid,
    input  logic                     s_wready,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [STRB_W-1:0]        s_wstrb,
    input  logic                     s_bvalid,
    output logic                     s_bready,
    input  logic [1:0]               s_bresp,
    output logic                     s_arvalid,
    input  logic                     s_arready,
    output logic [ADDR_W-1:0]        s_araddr,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    input  logic [DATA_W-1:0]        s_rdata,
    input  logic [1:0]               s_rresp
);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   last_g_q, last_g_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [NUM_M-1:0] req;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    cand;
    logic             found;
    logic             aw_hs;
    logic             w_hs;

    assign req = m_awvalid | m_arvalid;

    // Search order starts just after the last winner; the modulo keeps the
    // wrap correct when NUM_M is not a power of two.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (RR_EN != 0) begin
                cand = GW'((int'(last_g_q) + 1 + k) % NUM_M);
            end else begin
                cand = GW'(k);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_g_d  = last_g_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;

        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = pick;
                    state_d = m_awvalid[pick] ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                s_awvalid       = m_awvalid[g_q] & ~aw_done_q;
                s_awaddr        = m_awaddr[int'(g_q)*ADDR_W +: ADDR_W];
                m_awready[g_q]  = s_awready & ~aw_done_q;
                s_wvalid        = m_wvalid[g_q] & ~w_done_q;
                s_wdata         = m_wdata[int'(g_q)*DATA_W +: DATA_W];
                s_wstrb         = m_wstrb[int'(g_q)*STRB_W +: STRB_W];
                m_wready[g_q]   = s_wready & ~w_done_q;
                aw_hs           = s_awvalid & s_awready;
                w_hs            = s_wvalid & s_wready;
                aw_done_d       = aw_done_q | aw_hs;
                w_done_d        = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                m_bvalid[g_q]              = s_bvalid;
                m_bresp[int'(g_q)*2 +: 2]  = s_bresp;
                s_bready                   = m_bready[g_q];
                if (s_bvalid && m_bready[g_q]) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    last_g_d  = g_q;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                s_arvalid      = m_arvalid[g_q];
                s_araddr       = m_araddr[int'(g_q)*ADDR_W +: ADDR_W];
                m_arready[g_q] = s_arready;
                if (m_arvalid[g_q] && s_arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                m_rvalid[g_q]                      = s_rvalid;
                m_rdata[int'(g_q)*DATA_W +: DATA_W] = s_rdata;
                m_rresp[int'(g_q)*2 +: 2]          = s_rresp;
                s_rready                           = m_rready[g_q];
                if (s_rvalid && m_rready[g_q]) begin
                    last_g_d = g_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_g resets to the top index so master 0 wins the first arbitration.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            g_q       <= '0;
            last_g_q  <= GW'(NUM_M - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_g_q  <= last_g_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_vga_axil_arbiter.sv
// Directed bench for vga_axil_arbiter: a round-robin instance with a scripted
// slave plus a fixed-priority instance behind an always-ready slave.
module tb_vga_axil_arbiter;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    // shared master data inputs
    logic [63:0] m_awaddr, m_wdata, m_araddr;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_bready, m_rready;

    // round-robin instance
    logic [1:0]  m_awvalid, m_wvalid, m_arvalid;
    logic [1:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [3:0]  m_bresp, m_rresp;
    logic [63:0] m_rdata;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    // fixed-priority instance
    logic [1:0]  f_m_awvalid, f_m_wvalid, f_m_arvalid;
    logic [1:0]  f_m_awready, f_m_wready, f_m_bvalid, f_m_arready, f_m_rvalid;
    logic [3:0]  f_m_bresp, f_m_rresp;
    logic [63:0] f_m_rdata;
    logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;
    logic [31:0] f_s_awaddr, f_s_wdata, f_s_araddr;
    logic [3:0]  f_s_wstrb;

    logic [14:0] vr_main, vr_fp;
    assign vr_main = {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                      m_awready, m_wready, m_bvalid, m_arready, m_rvalid};
    assign vr_fp   = {f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready,
                      f_m_awready, f_m_wready, f_m_bvalid, f_m_arready, f_m_rvalid};

    int checks = 0;
    int errors = 0;
    int ord_rr, len_rr, ord_fp, len_fp;
    int aw_cnt, w_cnt;

    vga_axil_arbiter #(.NUM_M(2), .RR_EN(1)) dut (
        .clk(clk), .arst(arst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    vga_axil_arbiter #(.NUM_M(2), .RR_EN(0)) dut_fp (
        .clk(clk), .arst(arst),
        .m_awvalid(f_m_awvalid), .m_awready(f_m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(f_m_wvalid), .m_wready(f_m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(f_m_bvalid), .m_bready(m_bready), .m_bresp(f_m_bresp),
        .m_arvalid(f_m_arvalid), .m_arready(f_m_arready), .m_araddr(m_araddr),
        .m_rvalid(f_m_rvalid), .m_rready(m_rready), .m_rdata(f_m_rdata), .m_rresp(f_m_rresp),
        .s_awvalid(f_s_awvalid), .s_awready(1'b1), .s_awaddr(f_s_awaddr),
        .s_wvalid(f_s_wvalid), .s_wready(1'b1), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb),
        .s_bvalid(1'b1), .s_bready(f_s_bready), .s_bresp(2'b00),
        .s_arvalid(f_s_arvalid), .s_arready(1'b1), .s_araddr(f_s_araddr),
        .s_rvalid(1'b1), .s_rready(f_s_rready), .s_rdata(32'h0), .s_rresp(2'b00)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives the round-robin instance's slave handshake inputs.
    task automatic applyStimulus(input logic awr, input logic wr, input logic arr,
                                 input logic bv, input logic rv);
        s_awready = awr;
        s_wready  = wr;
        s_arready = arr;
        s_bvalid  = bv;
        s_rvalid  = rv;
    endtask

    task automatic clearInputs();
        m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
        f_m_awvalid = '0; f_m_wvalid = '0; f_m_arvalid = '0;
        m_awaddr = '0; m_wdata = '0; m_araddr = '0; m_wstrb = '0;
        m_bready = '0; m_rready = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_bresp = '0; s_rresp = '0; s_rdata = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        arst = 1'b1;
        clearInputs();
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        nextCycle();
    endtask

    // Both instances run the same request mix; each master drops a valid once
    // its handshake is seen. Grant order is recorded as a bit string, oldest first.
    task automatic runRace(input int rd0, input int wr0, input int rd1, input int wr1);
        int rd_a[2], wr_a[2], rd_b[2], wr_b[2];
        int rem;
        rd_a[0] = rd0; wr_a[0] = wr0; rd_a[1] = rd1; wr_a[1] = wr1;
        rd_b = rd_a; wr_b = wr_a;
        ord_rr = 0; len_rr = 0; ord_fp = 0; len_fp = 0;
        rem = rd0 + wr0 + rd1 + wr1;
        for (int cyc = 0; cyc < 80 && rem > 0; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                m_arvalid[m]   = rd_a[m] > 0;
                m_awvalid[m]   = wr_a[m] > 0;
                m_wvalid[m]    = wr_a[m] > 0;
                f_m_arvalid[m] = rd_b[m] > 0;
                f_m_awvalid[m] = wr_b[m] > 0;
                f_m_wvalid[m]  = wr_b[m] > 0;
            end
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if ((m_arvalid[m] && m_arready[m]) || (m_awvalid[m] && m_awready[m])) begin
                    if (m_arvalid[m] && m_arready[m]) rd_a[m]--; else wr_a[m]--;
                    ord_rr = (ord_rr << 1) | m;
                    len_rr++;
                end
                if ((f_m_arvalid[m] && f_m_arready[m]) || (f_m_awvalid[m] && f_m_awready[m])) begin
                    if (f_m_arvalid[m] && f_m_arready[m]) rd_b[m]--; else wr_b[m]--;
                    ord_fp = (ord_fp << 1) | m;
                    len_fp++;
                end
            end
            rem = rd_a[0] + wr_a[0] + rd_a[1] + wr_a[1] + rd_b[0] + wr_b[0] + rd_b[1] + wr_b[1];
            nextCycle();
        end
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        f_m_arvalid = '0; f_m_awvalid = '0; f_m_wvalid = '0;
        repeat (3) nextCycle();
        checkOutput("race_done", 64'(rem), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset with requests and slave readies asserted: everything stays gated.
        arst = 1'b1;
        clearInputs();
        m_awvalid = 2'b11; m_arvalid = 2'b11; f_m_arvalid = 2'b11;
        m_awaddr = 64'h0000_0020_0000_0010;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_vr_main", 64'(vr_main), 64'd0);
        checkOutput("rst_vr_fp", 64'(vr_fp), 64'd0);
        checkOutput("rst_awaddr", 64'(s_awaddr), 64'd0);
        clearInputs();
        arst = 1'b0;
        nextCycle();

        // Single write from m0.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
        m_awaddr[31:0] = 32'h10; m_wdata[31:0] = 32'hDEAD_BEEF; m_wstrb[3:0] = 4'hF;
        @(negedge clk);
        checkOutput("t1_idle_bubble", 64'(s_awvalid), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_awaddr", 64'(s_awaddr), 64'h10);
        checkOutput("t1_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        checkOutput("t1_wstrb", 64'(s_wstrb), 64'hF);
        checkOutput("t1_awready", 64'(m_awready), 64'b01);
        checkOutput("t1_wready", 64'(m_wready), 64'b01);
        nextCycle();
        m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        @(negedge clk);
        checkOutput("t1_bvalid", 64'(m_bvalid), 64'b01);
        checkOutput("t1_bresp", 64'(m_bresp), 64'h0);
        checkOutput("t1_bready", 64'(s_bready), 64'd1);
        nextCycle();
        s_bvalid = 1'b0;
        @(negedge clk);
        checkOutput("t1_back_idle", 64'(vr_main), 64'd0);

        // Single read from m1 with SLVERR.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        m_arvalid = 2'b10; m_araddr[63:32] = 32'h04; m_rready = 2'b10;
        @(negedge clk);
        checkOutput("t2_idle_bubble", 64'(s_arvalid), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_arvalid", 64'(s_arvalid), 64'd1);
        checkOutput("t2_araddr", 64'(s_araddr), 64'h04);
        checkOutput("t2_arready", 64'(m_arready), 64'b10);
        nextCycle();
        m_arvalid = '0;
        s_rvalid = 1'b1; s_rdata = 32'h1234; s_rresp = 2'b10;
        @(negedge clk);
        checkOutput("t2_rvalid", 64'(m_rvalid), 64'b10);
        checkOutput("t2_rdata", 64'(m_rdata[63:32]), 64'h1234);
        checkOutput("t2_rresp", 64'(m_rresp[3:2]), 64'h2);
        nextCycle();
        s_rvalid = 1'b0;

        // Contention from reset, then both request again.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        m_bready = 2'b11; m_rready = 2'b11;
        runRace(1, 0, 1, 0);
        checkOutput("t3_rr_order", 64'(ord_rr), 64'b01);
        checkOutput("t3_rr_len", 64'(len_rr), 64'd2);
        checkOutput("t3_fp_order", 64'(ord_fp), 64'b01);
        runRace(1, 0, 1, 0);
        checkOutput("t3_rr_again", 64'(ord_rr), 64'b01);
        checkOutput("t3_fp_again", 64'(ord_fp), 64'b01);

        // Fairness: m0 four reads against one m1 write.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        m_bready = 2'b11; m_rready = 2'b11;
        runRace(4, 0, 0, 1);
        checkOutput("t4_rr_order", 64'(ord_rr), 64'b01000);
        checkOutput("t4_rr_len", 64'(len_rr), 64'd5);
        checkOutput("t4_fp_order", 64'(ord_fp), 64'b00001);
        checkOutput("t4_fp_len", 64'(len_fp), 64'd5);

        // W accepted three cycles ahead of AW; m0 keeps wvalid high throughout.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
        aw_cnt = 0; w_cnt = 0;
        nextCycle();
        for (int c = 1; c <= 5; c++) begin
            s_awready = (c >= 4);
            @(negedge clk);
            if (s_awvalid && s_awready) aw_cnt++;
            if (s_wvalid && s_wready) w_cnt++;
            checkOutput($sformatf("t5_bvalid_c%0d", c), 64'(m_bvalid[0]), 64'(c == 5));
            nextCycle();
            if (aw_cnt > 0) m_awvalid = '0;
        end
        m_wvalid = '0;
        s_bvalid = 1'b0;
        checkOutput("t5_aw_count", 64'(aw_cnt), 64'd1);
        checkOutput("t5_w_count", 64'(w_cnt), 64'd1);

        // Reset while stalled in the write response.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b00;
        nextCycle();
        @(negedge clk);
        checkOutput("t6_awvalid", 64'(s_awvalid), 64'd1);
        nextCycle();
        m_awvalid = '0; m_wvalid = '0;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("t6_stall_bvalid", 64'(m_bvalid), 64'b01);
        #1 arst = 1'b1;
        #1;
        checkOutput("t6_rst_vr", 64'(vr_main), 64'd0);
        checkOutput("t6_rst_awaddr", 64'(s_awaddr), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        m_bready = 2'b11; m_rready = 2'b11;
        runRace(1, 0, 1, 0);
        checkOutput("t6_rr_order", 64'(ord_rr), 64'b01);
        checkOutput("t6_fp_order", 64'(ord_fp), 64'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
